eco32f_dbus_ctrl: RTL and testbench
===================================

Name: eco32f_dbus_ctrl

Overview:
- Parametrised data-bus engine for the eco32f memory stage: all Wishbone traffic between the LSU/dcache and the data bus.
- Posted write buffer of configurable depth.
- Configurable refill burst length with critical-word-first wrap.
- Single-beat uncached reads.
- Bus-error reporting, which the current LSU lacks.
- The LSU issues requests and consumes responses; cache tag/data arrays stay in the LSU.

Parameters:
WBUF_DEPTH_LOG2, 2, log2 of write-buffer entries (4 entries); legal 1..4
LINE_WORDS_LOG2, 3, log2 of words per cache line (8 words = 32 bytes); legal 2..4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request strobe
req_ready  out  1  request accepted when req_valid & req_ready
req_type  in  2  0 = uncached read, 1 = line refill, 2 = write, 3 = reserved (accepted, ignored)
req_addr  in  32  physical byte address
req_sel  in  4  byte selects (write only; reads use 4'b1111)
req_wdata  in  32  write data, byte lanes pre-replicated
rsp_valid  out  1  one-cycle pulse per returned read word
rsp_addr  out  32  word address of rsp_data
rsp_data  out  32  read data
rsp_last  out  1  final word of the request
rsp_err  out  1  bus error on this word; always with rsp_last
wbuf_empty  out  1  no writes pending or in flight
wbuf_err  out  1  one-cycle pulse when a posted write ends in error
dwbm_adr_o  out  32  Wishbone address
dwbm_dat_o  out  32  write data
dwbm_sel_o  out  4  byte selects
dwbm_we_o  out  1  write enable
dwbm_stb_o  out  1  strobe
dwbm_cyc_o  out  1  cycle
dwbm_cti_o  out  3  cycle type
dwbm_bte_o  out  2  burst type
dwbm_ack_i  in  1  acknowledge
dwbm_err_i  in  1  error
dwbm_rty_i  in  1  retry
dwbm_dat_i  in  32  read data

Behaviour:
- Reset values: stb/cyc/we = 0, rsp_valid = 0, rsp_last = 0, rsp_err = 0, wbuf_err = 0, adr/sel/dat = 0, wbuf empty (wbuf_empty = 1), state IDLE.
- req_ready is combinational.
  - Type 2: high when the write buffer is not full, in any state.
  - Types 0/1: high only in IDLE with wbuf_empty = 1; reads never pass buffered writes.
- A write enqueued in the same cycle as a dequeue is accepted when the buffer is full-minus-zero-free only if the dequeue frees a slot; req_ready does not depend on the dequeue.
- FSM states: IDLE, WRITE, READ, REFILL.
- IDLE:
  - Wbuf non-empty -> WRITE; stb = cyc = we = 1, head entry on adr/sel/dat, cti = 3'b111.
  - Else accepted read -> READ or REFILL.
  - Bus asserted the cycle after acceptance.
- WRITE:
  - On ack: pop entry. Next entry pending -> next write issued the following cycle (stb drops for one cycle). Else -> IDLE.
  - On err: pop entry, pulse wbuf_err, continue the same way.
- READ:
  - sel = 1111, cti = 3'b111.
  - On ack or err: rsp_valid = rsp_last = 1 next cycle, rsp_err = err, -> IDLE.
- REFILL:
  - First beat at req_addr word-aligned (critical word first). Address increments by 4 and wraps within the line (low LINE_WORDS_LOG2+2 bits only).
  - bte: 2'b01 / 2'b10 / 2'b11 for 4 / 8 / 16 words.
  - cti = 3'b010 for every beat except the last, which uses 3'b111.
  - Each ack -> rsp_valid with that beat's address/data, one cycle later.
  - Last beat sets rsp_last.
  - err on any beat: terminate burst (stb = cyc = 0), rsp_err = rsp_last = 1, -> IDLE.
- Beat counter is LINE_WORDS_LOG2 bits; it counts down to 0.
- ack and err together: err wins.
- rty_i without the feature: treated as err.
- rst mid-burst: bus dropped the next edge; buffered writes discarded; no response issued.

Optional Feature:
ECO32F_DBUS_RETRY_EN
- Defined:
  - rty_i deasserts stb/cyc for one cycle, then reissues the same beat; the refill burst resumes from the retried address.
  - Retries are unbounded.
  - rty_i never produces rsp_err or wbuf_err.
- Undefined: rty_i behaves exactly as err_i.

Test Plan:
- Refill, req_addr = 0x0000_1014, LINE_WORDS_LOG2 = 3, zero-wait ack -> 8 responses at 0x14, 0x18, 0x1C, 0x00 … 0x10. cti = 010 ×7 then 111. bte = 10. rsp_last on 0x10 only.
- Post 5 writes with WBUF_DEPTH_LOG2 = 2 and ack held low -> req_ready low on the 5th. Once ack resumes -> writes drain in order; wbuf_empty = 1 after the 4th ack.
- Write to 0x100 buffered, then uncached read of 0x100 -> read not accepted until the write is acked. Bus order: write then read.
- Err on beat 3 of a refill -> 3 normal responses, then rsp_err = rsp_last = 1; cyc = 0 next cycle; state IDLE.
- Write err -> single wbuf_err pulse; next buffered write still issued.
- Retry build: rty_i on beat 2 of a refill -> one idle cycle, same address reissued; 8 clean responses; no rsp_err. Non-retry build: same stimulus -> rsp_err.

Source files
------------

// File: rtl/eco32f_dbus_ctrl.sv
// eco32f data-bus engine: posted write buffer, critical-word-first wrapping refills, uncached reads.
// Optional ECO32F_DBUS_RETRY_EN: rty_i backs off one cycle and reissues the beat instead of erroring.
module eco32f_dbus_ctrl #(
  parameter int WBUF_DEPTH_LOG2 = 2,
  parameter int LINE_WORDS_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        wbuf_empty,
  output logic        wbuf_err,
  output logic [31:0] dwbm_adr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_cyc_o,
  output logic [2:0]  dwbm_cti_o,
  output logic [1:0]  dwbm_bte_o,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  input  logic        dwbm_rty_i,
  input  logic [31:0] dwbm_dat_i
);

  localparam int WBUF_DEPTH = 1 << WBUF_DEPTH_LOG2;
  localparam logic [WBUF_DEPTH_LOG2:0]   WBUF_FULL = {1'b1, {WBUF_DEPTH_LOG2{1'b0}}};
  localparam logic [WBUF_DEPTH_LOG2:0]   CNT_ONE   = {{WBUF_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [WBUF_DEPTH_LOG2-1:0] PTR_ONE   = {{(WBUF_DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [LINE_WORDS_LOG2-1:0] BEAT_ONE  = {{(LINE_WORDS_LOG2-1){1'b0}}, 1'b1};
  localparam logic [1:0] REFILL_BTE = (LINE_WORDS_LOG2 == 2) ? 2'b01 :
                                      (LINE_WORDS_LOG2 == 3) ? 2'b10 : 2'b11;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;
  localparam logic [1:0] REQ_UNCACHED = 2'd0;
  localparam logic [1:0] REQ_REFILL   = 2'd1;
  localparam logic [1:0] REQ_WRITE    = 2'd2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, REFILL} state_t;

  state_t state;

  // Posted write buffer; the head entry stays resident until its bus cycle terminates.
  logic [31:0] wb_adr [WBUF_DEPTH];
  logic [31:0] wb_dat [WBUF_DEPTH];
  logic [3:0]  wb_sel [WBUF_DEPTH];
  logic [WBUF_DEPTH_LOG2-1:0] wr_ptr;
  logic [WBUF_DEPTH_LOG2-1:0] rd_ptr;
  logic [WBUF_DEPTH_LOG2:0]   wb_cnt;
  logic wb_full;
  logic push;
  logic pop;

  logic [LINE_WORDS_LOG2-1:0] beat_cnt;
  logic [LINE_WORDS_LOG2-1:0] line_word;
  logic [LINE_WORDS_LOG2-1:0] line_word_nxt;

  logic bus_act;
  logic bus_ack;
  logic bus_err;
  logic bus_rty;

  assign bus_act = dwbm_cyc_o & dwbm_stb_o;

`ifdef ECO32F_DBUS_RETRY_EN
  assign bus_err = bus_act & dwbm_err_i;
  assign bus_rty = bus_act & dwbm_rty_i & ~dwbm_err_i;
`else
  assign bus_err = bus_act & (dwbm_err_i | dwbm_rty_i);
  assign bus_rty = 1'b0;
`endif

  assign bus_ack = bus_act & dwbm_ack_i & ~bus_err & ~bus_rty;

  assign wbuf_empty = (wb_cnt == '0);
  assign wb_full    = (wb_cnt == WBUF_FULL);
  assign push       = req_valid & req_ready & (req_type == REQ_WRITE);
  assign pop        = (state == WRITE) & (bus_ack | bus_err);

  assign line_word     = dwbm_adr_o[LINE_WORDS_LOG2+1:2];
  assign line_word_nxt = line_word + BEAT_ONE;

  // Reads wait for an empty buffer so they can never overtake a posted write.
  always_comb begin
    req_ready = 1'b1;
    case (req_type)
      REQ_WRITE:               req_ready = ~wb_full;
      REQ_UNCACHED, REQ_REFILL: req_ready = (state == IDLE) & wbuf_empty;
      default:                 req_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_adr[wr_ptr] <= req_addr;
      wb_dat[wr_ptr] <= req_wdata;
      wb_sel[wr_ptr] <= req_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wb_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   wb_cnt <= wb_cnt + CNT_ONE;
        2'b01:   wb_cnt <= wb_cnt - CNT_ONE;
        default: wb_cnt <= wb_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dwbm_adr_o <= '0;
      dwbm_dat_o <= '0;
      dwbm_sel_o <= '0;
      dwbm_we_o  <= 1'b0;
      dwbm_stb_o <= 1'b0;
      dwbm_cyc_o <= 1'b0;
      dwbm_cti_o <= '0;
      dwbm_bte_o <= '0;
      rsp_valid  <= 1'b0;
      rsp_addr   <= '0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
      wbuf_err   <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      wbuf_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!wbuf_empty) begin
            dwbm_adr_o <= wb_adr[rd_ptr];
            dwbm_dat_o <= wb_dat[rd_ptr];
            dwbm_sel_o <= wb_sel[rd_ptr];
            dwbm_we_o  <= 1'b1;
            dwbm_stb_o <= 1'b1;
            dwbm_cyc_o <= 1'b1;
            dwbm_cti_o <= CTI_END;
            dwbm_bte_o <= 2'b00;
            state      <= WRITE;
          end else if (req_valid && req_ready &&
                       (req_type == REQ_UNCACHED || req_type == REQ_REFILL)) begin
            dwbm_adr_o <= {req_addr[31:2], 2'b00};
            dwbm_sel_o <= 4'b1111;
            dwbm_we_o  <= 1'b0;
            dwbm_stb_o <= 1'b1;
            dwbm_cyc_o <= 1'b1;
            if (req_type == REQ_REFILL) begin
              dwbm_cti_o <= CTI_INCR;
              dwbm_bte_o <= REFILL_BTE;
              beat_cnt   <= '1;
              state      <= REFILL;
            end else begin
              dwbm_cti_o <= CTI_END;
              dwbm_bte_o <= 2'b00;
              state      <= READ;
            end
          end
        end

        // Every termination (including retry) returns to IDLE, which reissues the head entry.
        WRITE: begin
          if (bus_ack || bus_err || bus_rty) begin
            dwbm_stb_o <= 1'b0;
            dwbm_cyc_o <= 1'b0;
            dwbm_we_o  <= 1'b0;
            wbuf_err   <= bus_err;
            state      <= IDLE;
          end
        end

        READ: begin
          if (!dwbm_stb_o) begin
            dwbm_stb_o <= 1'b1;
            dwbm_cyc_o <= 1'b1;
          end else if (bus_ack || bus_err) begin
            dwbm_stb_o <= 1'b0;
            dwbm_cyc_o <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_last   <= 1'b1;
            rsp_err    <= bus_err;
            rsp_addr   <= dwbm_adr_o;
            rsp_data   <= dwbm_dat_i;
            state      <= IDLE;
          end else if (bus_rty) begin
            dwbm_stb_o <= 1'b0;
            dwbm_cyc_o <= 1'b0;
          end
        end

        REFILL: begin
          if (!dwbm_stb_o) begin
            dwbm_stb_o <= 1'b1;
            dwbm_cyc_o <= 1'b1;
          end else if (bus_err) begin
            dwbm_stb_o <= 1'b0;
            dwbm_cyc_o <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_last   <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_addr   <= dwbm_adr_o;
            rsp_data   <= dwbm_dat_i;
            state      <= IDLE;
          end else if (bus_ack) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= dwbm_adr_o;
            rsp_data  <= dwbm_dat_i;
            if (beat_cnt == '0) begin
              rsp_last   <= 1'b1;
              dwbm_stb_o <= 1'b0;
              dwbm_cyc_o <= 1'b0;
              state      <= IDLE;
            end else begin
              beat_cnt   <= beat_cnt - BEAT_ONE;
              dwbm_adr_o <= {dwbm_adr_o[31:LINE_WORDS_LOG2+2], line_word_nxt, 2'b00};
              if (beat_cnt == BEAT_ONE) dwbm_cti_o <= CTI_END;
            end
          end else if (bus_rty) begin
            dwbm_stb_o <= 1'b0;
            dwbm_cyc_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eco32f_dbus_ctrl.sv
// Directed bench for eco32f_dbus_ctrl with a zero-wait Wishbone slave that can inject err/rty on a chosen beat.
module tb_eco32f_dbus_ctrl;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        wbuf_empty;
  logic        wbuf_err;
  logic [31:0] dwbm_adr_o;
  logic [31:0] dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o;
  logic        dwbm_stb_o;
  logic        dwbm_cyc_o;
  logic [2:0]  dwbm_cti_o;
  logic [1:0]  dwbm_bte_o;
  logic        dwbm_ack_i;
  logic        dwbm_err_i;
  logic        dwbm_rty_i;
  logic [31:0] dwbm_dat_i;

  int tests;
  int fails;

  // Slave configuration and logs of acked beats / responses.
  bit          ack_en;
  int          fail_beat;
  bit          fail_rty;
  bit          fail_done;
  logic [31:0] fail_adr;
  int          slv_beats;
  int          wbuf_err_cnt;
  logic [31:0] b_adr[$];
  logic [31:0] b_dat[$];
  logic [3:0]  b_sel[$];
  logic        b_we[$];
  logic [2:0]  b_cti[$];
  logic [1:0]  b_bte[$];
  logic [31:0] r_adr[$];
  logic [31:0] r_dat[$];
  logic        r_last[$];
  logic        r_err[$];

  eco32f_dbus_ctrl #(.WBUF_DEPTH_LOG2(2), .LINE_WORDS_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .wbuf_empty(wbuf_empty), .wbuf_err(wbuf_err),
    .dwbm_adr_o(dwbm_adr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_we_o(dwbm_we_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_cyc_o(dwbm_cyc_o),
    .dwbm_cti_o(dwbm_cti_o), .dwbm_bte_o(dwbm_bte_o),
    .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i), .dwbm_rty_i(dwbm_rty_i),
    .dwbm_dat_i(dwbm_dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0; dwbm_rty_i = 1'b0; dwbm_dat_i = '0;
    forever begin
      @(negedge clk);
      dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0; dwbm_rty_i = 1'b0;
      if (dwbm_cyc_o && dwbm_stb_o && !rst) begin
        if (slv_beats == fail_beat && !fail_done) begin
          fail_done = 1'b1;
          fail_adr  = dwbm_adr_o;
          if (fail_rty) dwbm_rty_i = 1'b1;
          else          dwbm_err_i = 1'b1;
          slv_beats++;
        end else if (ack_en) begin
          dwbm_ack_i = 1'b1;
          dwbm_dat_i = dwbm_adr_o ^ KEY;
          b_adr.push_back(dwbm_adr_o); b_dat.push_back(dwbm_dat_o);
          b_sel.push_back(dwbm_sel_o); b_we.push_back(dwbm_we_o);
          b_cti.push_back(dwbm_cti_o); b_bte.push_back(dwbm_bte_o);
          slv_beats++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        r_adr.push_back(rsp_addr); r_dat.push_back(rsp_data);
        r_last.push_back(rsp_last); r_err.push_back(rsp_err);
      end
      if (wbuf_err) wbuf_err_cnt++;
    end
  end

  task automatic clear_logs(input bit ack, input int fbeat, input bit frty);
    ack_en = ack; fail_beat = fbeat; fail_rty = frty; fail_done = 1'b0;
    slv_beats = 0; wbuf_err_cnt = 0;
    b_adr.delete(); b_dat.delete(); b_sel.delete(); b_we.delete(); b_cti.delete(); b_bte.delete();
    r_adr.delete(); r_dat.delete(); r_last.delete(); r_err.delete();
  endtask

  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_type = t; req_addr = a; req_sel = s; req_wdata = d;
    #1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); #1; n++; end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL issue_accept type=%0d addr=%h ready=%b want 1", t, a, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_last(input string name);
    int n;
    n = 0;
    while (!(rsp_valid && rsp_last) && n < 300) begin @(negedge clk); n++; end
    #1;
    tests++;
    if (!(rsp_valid && rsp_last)) begin
      fails++; $display("FAIL %s_timeout rsp_last=%b want 1", name, rsp_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_type = 2'd0; req_addr = '0; req_sel = '0; req_wdata = '0;
    clear_logs(1'b1, -1, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if ({dwbm_stb_o, dwbm_cyc_o, dwbm_we_o, rsp_valid, rsp_last, rsp_err, wbuf_err} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b want 0000000",
        {dwbm_stb_o, dwbm_cyc_o, dwbm_we_o, rsp_valid, rsp_last, rsp_err, wbuf_err});
    end
    tests++;
    if ({dwbm_adr_o, dwbm_dat_o, dwbm_sel_o} !== 68'h0) begin
      fails++; $display("FAIL reset_bus adr=%h dat=%h sel=%h want 0", dwbm_adr_o, dwbm_dat_o, dwbm_sel_o);
    end
    tests++;
    if (wbuf_empty !== 1'b1) begin fails++; $display("FAIL reset_wbuf_empty got=%b want 1", wbuf_empty); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_read_ready got=%b want 1", req_ready); end
  endtask

  task automatic test_refill();
    logic [31:0] ea;
    clear_logs(1'b1, -1, 1'b0);
    issue(2'd1, 32'h0000_1014, 4'hF, 32'h0);
    wait_last("refill");
    tests++;
    if (r_adr.size() != 8) begin fails++; $display("FAIL refill_count got=%0d want 8", r_adr.size()); end
    for (int i = 0; i < 8 && i < r_adr.size() && i < b_adr.size(); i++) begin
      ea = 32'h0000_1000 | ((32'h14 + 32'(4 * i)) & 32'h1F);
      tests++;
      if (r_adr[i] !== ea || r_dat[i] !== (ea ^ KEY) || r_last[i] !== (i == 7) || r_err[i] !== 1'b0) begin
        fails++; $display("FAIL refill_rsp%0d adr=%h dat=%h last=%b err=%b want adr=%h dat=%h last=%b err=0",
          i, r_adr[i], r_dat[i], r_last[i], r_err[i], ea, ea ^ KEY, (i == 7));
      end
      tests++;
      if (b_adr[i] !== ea || b_cti[i] !== ((i == 7) ? 3'b111 : 3'b010) || b_bte[i] !== 2'b10 || b_sel[i] !== 4'hF) begin
        fails++; $display("FAIL refill_bus%0d adr=%h cti=%b bte=%b sel=%h want adr=%h cti=%b bte=10 sel=f",
          i, b_adr[i], b_cti[i], b_bte[i], b_sel[i], ea, (i == 7) ? 3'b111 : 3'b010);
      end
    end
  endtask

  task automatic test_wbuf_full();
    bit blocked;
    int n;
    clear_logs(1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++)
      issue(2'd2, 32'h500 + 32'(4 * i), 4'b0001 << i, 32'hA000_0000 + 32'(i));
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd2; req_addr = 32'h510; req_sel = 4'hF; req_wdata = 32'hA000_0004;
    #1;
    blocked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (req_ready !== 1'b0) blocked = 1'b0;
      @(negedge clk); #1;
    end
    tests++;
    if (blocked !== 1'b1) begin fails++; $display("FAIL wbuf_full_ready got=%b want 0", req_ready); end
    tests++;
    if (dwbm_stb_o !== 1'b1 || dwbm_we_o !== 1'b1 || dwbm_adr_o !== 32'h500 || dwbm_cti_o !== 3'b111) begin
      fails++; $display("FAIL wbuf_head_bus stb=%b we=%b adr=%h cti=%b want 1 1 00000500 111",
        dwbm_stb_o, dwbm_we_o, dwbm_adr_o, dwbm_cti_o);
    end
    req_valid = 1'b0;
    ack_en = 1'b1;
    n = 0;
    while (!wbuf_empty && n < 200) begin @(negedge clk); n++; end
    #1;
    tests++;
    if (wbuf_empty !== 1'b1 || b_adr.size() != 4) begin
      fails++; $display("FAIL wbuf_drain empty=%b acks=%0d want 1 and 4", wbuf_empty, b_adr.size());
    end
    for (int i = 0; i < 4 && i < b_adr.size(); i++) begin
      tests++;
      if (b_adr[i] !== 32'h500 + 32'(4 * i) || b_dat[i] !== 32'hA000_0000 + 32'(i) ||
          b_sel[i] !== (4'b0001 << i) || b_we[i] !== 1'b1) begin
        fails++; $display("FAIL wbuf_order%0d adr=%h dat=%h sel=%b we=%b want adr=%h dat=%h sel=%b we=1",
          i, b_adr[i], b_dat[i], b_sel[i], b_we[i], 32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b0001 << i);
      end
    end
  endtask

  task automatic test_read_after_write();
    bit blocked;
    clear_logs(1'b0, -1, 1'b0);
    issue(2'd2, 32'h100, 4'b0011, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd0; req_addr = 32'h100; req_sel = 4'hF; req_wdata = '0;
    #1;
    blocked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (req_ready !== 1'b0) blocked = 1'b0;
      @(negedge clk); #1;
    end
    tests++;
    if (blocked !== 1'b1) begin fails++; $display("FAIL raw_read_blocked ready=%b want 0", req_ready); end
    req_valid = 1'b0;
    ack_en = 1'b1;
    issue(2'd0, 32'h100, 4'hF, 32'h0);
    wait_last("raw");
    tests++;
    if (b_adr.size() != 2) begin fails++; $display("FAIL raw_bus_count got=%0d want 2", b_adr.size()); end
    else begin
      tests++;
      if (b_we[0] !== 1'b1 || b_adr[0] !== 32'h100 || b_dat[0] !== 32'h1122_3344 || b_sel[0] !== 4'b0011) begin
        fails++; $display("FAIL raw_first_write we=%b adr=%h dat=%h sel=%b want 1 00000100 11223344 0011",
          b_we[0], b_adr[0], b_dat[0], b_sel[0]);
      end
      tests++;
      if (b_we[1] !== 1'b0 || b_adr[1] !== 32'h100 || b_sel[1] !== 4'hF || b_cti[1] !== 3'b111) begin
        fails++; $display("FAIL raw_second_read we=%b adr=%h sel=%b cti=%b want 0 00000100 1111 111",
          b_we[1], b_adr[1], b_sel[1], b_cti[1]);
      end
    end
    tests++;
    if (r_adr.size() != 1 || r_adr[0] !== 32'h100 || r_dat[0] !== (32'h100 ^ KEY) || r_err[0] !== 1'b0) begin
      fails++; $display("FAIL raw_rsp n=%0d adr=%h dat=%h want 1 00000100 %h", r_adr.size(),
        rsp_addr, rsp_data, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_refill_err();
    clear_logs(1'b1, 3, 1'b0);
    issue(2'd1, 32'h2000, 4'hF, 32'h0);
    wait_last("rerr");
    tests++;
    if (rsp_err !== 1'b1 || dwbm_cyc_o !== 1'b0 || rsp_addr !== 32'h200C) begin
      fails++; $display("FAIL rerr_term err=%b cyc=%b adr=%h want 1 0 0000200c", rsp_err, dwbm_cyc_o, rsp_addr);
    end
    tests++;
    if (r_adr.size() != 4 || r_err[0] !== 1'b0 || r_err[2] !== 1'b0 || r_last[2] !== 1'b0 || r_adr[2] !== 32'h2008) begin
      fails++; $display("FAIL rerr_clean n=%0d want 4 with first three clean", r_adr.size());
    end
    req_type = 2'd0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rerr_idle ready=%b want 1", req_ready); end
  endtask

  task automatic test_write_err();
    int n;
    clear_logs(1'b1, 0, 1'b0);
    issue(2'd2, 32'h600, 4'hF, 32'hBEEF_0001);
    issue(2'd2, 32'h604, 4'hF, 32'hBEEF_0002);
    n = 0;
    while (!(wbuf_empty && b_adr.size() > 0) && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (wbuf_err_cnt != 1) begin fails++; $display("FAIL werr_pulses got=%0d want 1", wbuf_err_cnt); end
    tests++;
    if (b_adr.size() != 1 || b_adr[0] !== 32'h604 || b_dat[0] !== 32'hBEEF_0002) begin
      fails++; $display("FAIL werr_next_write acks=%0d want 1 at 00000604", b_adr.size());
    end
  endtask

  task automatic test_retry();
    clear_logs(1'b1, 2, 1'b1);
    issue(2'd1, 32'h3008, 4'hF, 32'h0);
    wait_last("retry");
`ifdef ECO32F_DBUS_RETRY_EN
    tests++;
    if (r_adr.size() != 8 || r_err.sum() != 0 || rsp_addr !== 32'h3004) begin
      fails++; $display("FAIL retry_clean n=%0d errs=%0d last_adr=%h want 8 0 00003004",
        r_adr.size(), r_err.sum(), rsp_addr);
    end
    tests++;
    if (fail_adr !== 32'h3010 || b_adr.size() < 3 || b_adr[2] !== 32'h3010) begin
      fails++; $display("FAIL retry_reissue rty_adr=%h want 00003010 reissued", fail_adr);
    end
`else
    tests++;
    if (r_adr.size() != 3 || rsp_err !== 1'b1 || rsp_addr !== 32'h3010) begin
      fails++; $display("FAIL rty_as_err n=%0d err=%b adr=%h want 3 1 00003010", r_adr.size(), rsp_err, rsp_addr);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    clear_logs(1'b0, -1, 1'b0);
    issue(2'd1, 32'h4000, 4'hF, 32'h0);
    issue(2'd2, 32'h400, 4'hF, 32'h7777_0000);
    @(negedge clk);
    tests++;
    if (dwbm_cyc_o !== 1'b1 || wbuf_empty !== 1'b0) begin
      fails++; $display("FAIL mid_setup cyc=%b empty=%b want 1 0", dwbm_cyc_o, wbuf_empty);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (dwbm_cyc_o !== 1'b0 || dwbm_stb_o !== 1'b0 || wbuf_empty !== 1'b1) begin
      fails++; $display("FAIL mid_reset cyc=%b stb=%b empty=%b want 0 0 1", dwbm_cyc_o, dwbm_stb_o, wbuf_empty);
    end
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (r_adr.size() != 0 || b_adr.size() != 0) begin
      fails++; $display("FAIL mid_quiet rsps=%0d acks=%0d want 0 0", r_adr.size(), b_adr.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_refill();
    test_wbuf_full();
    test_read_after_write();
    test_refill_err();
    test_write_err();
    test_retry();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
